// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with optional x0 hardwiring, write-to-read
// bypass and a one-entry-per-cycle clear sequencer.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_eff;

  // A write takes effect only in IDLE and never lands on a hardwired x0.
  assign wr_eff = we && (state == IDLE) && !((ZERO_REG != 0) && (waddr == '0));

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              wr_act,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if ((ZERO_REG != 0) && (ra == '0)) begin
      return '0;
    end else if ((BYPASS != 0) && wr_act && (wa == ra)) begin
      return wd;
    end else begin
      return stored;
    end
  endfunction

  assign rdata_a = read_port(raddr_a, mem[raddr_a], wr_eff, waddr, wdata);
  assign rdata_b = read_port(raddr_b, mem[raddr_b], wr_eff, waddr, wdata);

  // Array storage, clear sweep sequencing and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_eff) begin
            mem[waddr] <= wdata;
          end
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          idx      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
